// File: rtl/projectile_engine_pkg.sv
// Shared definitions for the projectile engine: look-direction encoding,
// visible screen size, the per-slot record and direction-to-step helpers.
package projectile_engine_pkg;

  localparam logic [2:0] DIR_N  = 3'd0;
  localparam logic [2:0] DIR_NE = 3'd1;
  localparam logic [2:0] DIR_E  = 3'd2;
  localparam logic [2:0] DIR_SE = 3'd3;
  localparam logic [2:0] DIR_S  = 3'd4;
  localparam logic [2:0] DIR_SW = 3'd5;
  localparam logic [2:0] DIR_W  = 3'd6;
  localparam logic [2:0] DIR_NW = 3'd7;

  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;

  typedef struct packed {
    logic       active;
    logic [9:0] x;
    logic [9:0] y;
    logic [2:0] dir;
  } slot_t;

  // Screen y grows downwards, so "north" is a negative y step.
  function automatic logic signed [1:0] dir_dx(input logic [2:0] dir);
    case (dir)
      DIR_NE, DIR_E, DIR_SE: return 2'sb01;
      DIR_SW, DIR_W, DIR_NW: return 2'sb11;
      default:               return 2'sb00;
    endcase
  endfunction

  function automatic logic signed [1:0] dir_dy(input logic [2:0] dir);
    case (dir)
      DIR_SE, DIR_S, DIR_SW: return 2'sb01;
      DIR_N, DIR_NE, DIR_NW: return 2'sb11;
      default:               return 2'sb00;
    endcase
  endfunction

  function automatic logic signed [10:0] axis_step(input logic signed [1:0] d,
                                                   input logic [10:0] mag);
    case (d)
      2'sb01:  return $signed(mag);
      2'sb11:  return -$signed(mag);
      default: return 11'sd0;
    endcase
  endfunction

endpackage

// File: rtl/projectile_slot.sv
// One projectile: position/direction registers, per-frame move with
// screen-edge retirement, and the combinational pixel-inside test.
module projectile_slot
  import projectile_engine_pkg::*;
#(
  parameter int SPEED    = 4,
  parameter int SIZE     = 4,
  parameter int PLAYER_X = 320,
  parameter int PLAYER_Y = 240
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear_all,
  input  logic       spawn,
  input  logic [2:0] spawn_dir,
  input  logic       retire,
  input  logic       frame_tick,
  input  logic [9:0] px_x,
  input  logic [9:0] px_y,
  output logic       active,
  output logic       hit
);

  localparam logic signed [10:0] X_MAX  = 11'(H_ACTIVE - SIZE);
  localparam logic signed [10:0] Y_MAX  = 11'(V_ACTIVE - SIZE);
  localparam logic [10:0]        STEP   = 11'(SPEED);
  localparam logic [10:0]        SIZE_W = 11'(SIZE);

  slot_t             slot_reg;
  logic signed [10:0] next_x;
  logic signed [10:0] next_y;
  logic               off_screen;
  logic [10:0]        qx;
  logic [10:0]        qy;
  logic [10:0]        sx;
  logic [10:0]        sy;

  always_comb begin
    next_x     = $signed({1'b0, slot_reg.x}) + axis_step(dir_dx(slot_reg.dir), STEP);
    next_y     = $signed({1'b0, slot_reg.y}) + axis_step(dir_dy(slot_reg.dir), STEP);
    off_screen = (next_x < 11'sd0) || (next_x > X_MAX) ||
                 (next_y < 11'sd0) || (next_y > Y_MAX);
  end

  // Spawn outranks a retire on the same slot; the parent only spawns into free slots.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_reg <= '0;
    end else if (clear_all) begin
      slot_reg <= '0;
    end else if (spawn) begin
      slot_reg <= '{active: 1'b1, x: 10'(PLAYER_X), y: 10'(PLAYER_Y), dir: spawn_dir};
    end else if (retire) begin
      slot_reg.active <= 1'b0;
    end else if (frame_tick && slot_reg.active) begin
      if (off_screen) begin
        slot_reg.active <= 1'b0;
      end else begin
        slot_reg.x <= next_x[9:0];
        slot_reg.y <= next_y[9:0];
      end
    end
  end

  always_comb begin
    qx  = {1'b0, px_x};
    qy  = {1'b0, px_y};
    sx  = {1'b0, slot_reg.x};
    sy  = {1'b0, slot_reg.y};
    hit = slot_reg.active &&
          (qx >= sx) && (qx < sx + SIZE_W) &&
          (qy >= sy) && (qy < sy + SIZE_W);
  end

  assign active = slot_reg.active;

endmodule

// File: rtl/projectile_engine.sv
// Projectile pool: shot edge detect, lowest-free-slot allocator, cooldown and
// pixel-hit OR-reduce. Define PROJECTILE_AUTOFIRE_EN to treat a held shoot as repeated requests.
module projectile_engine
  import projectile_engine_pkg::*;
#(
  parameter int NUM_SLOTS       = 4,
  parameter int SPEED           = 4,
  parameter int SIZE            = 4,
  parameter int COOLDOWN_FRAMES = 8,
  parameter int PLAYER_X        = 320,
  parameter int PLAYER_Y        = 240
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 frame_tick,
  input  logic                 game_active,
  input  logic [2:0]           look,
  input  logic                 shoot,
  input  logic [NUM_SLOTS-1:0] hit_clear,
  input  logic [9:0]           px_x,
  input  logic [9:0]           px_y,
  output logic                 px_hit,
  output logic [NUM_SLOTS-1:0] slot_active,
  output logic                 cooldown_busy,
  output logic                 shot_fired,
  output logic                 shot_dropped
);

  localparam int CD_W = $clog2(COOLDOWN_FRAMES + 1);

  logic [CD_W-1:0]      cooldown_reg;
  logic                 req_reg;
  logic [NUM_SLOTS-1:0] active_vec;
  logic [NUM_SLOTS-1:0] hit_vec;
  logic [NUM_SLOTS-1:0] free_vec;
  logic [NUM_SLOTS-1:0] spawn_vec;
  logic                 may_fire;
  logic                 accept;
  logic                 refuse;

  // The request is registered so acceptance lands two edges after the raw rise.
`ifdef PROJECTILE_AUTOFIRE_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) req_reg <= 1'b0;
    else     req_reg <= shoot;
  end
`else
  logic shoot_prev_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shoot_prev_reg <= 1'b0;
      req_reg        <= 1'b0;
    end else begin
      shoot_prev_reg <= shoot;
      req_reg        <= shoot & ~shoot_prev_reg;
    end
  end
`endif

  // Two's-complement trick isolates the lowest set bit of the free mask.
  always_comb begin
    free_vec  = ~active_vec;
    may_fire  = req_reg && game_active && (cooldown_reg == '0);
    accept    = may_fire && (|free_vec);
    refuse    = may_fire && !(|free_vec);
    spawn_vec = accept ? (free_vec & (~free_vec + NUM_SLOTS'(1))) : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cooldown_reg <= '0;
    end else if (!game_active) begin
      cooldown_reg <= '0;
    end else if (accept) begin
      cooldown_reg <= CD_W'(COOLDOWN_FRAMES);
    end else if (frame_tick && (cooldown_reg != '0)) begin
      cooldown_reg <= cooldown_reg - CD_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shot_fired   <= 1'b0;
      shot_dropped <= 1'b0;
      px_hit       <= 1'b0;
    end else begin
      shot_fired   <= accept;
      shot_dropped <= refuse;
      px_hit       <= |hit_vec;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SLOTS; gi++) begin : g_slot
      projectile_slot #(
        .SPEED    (SPEED),
        .SIZE     (SIZE),
        .PLAYER_X (PLAYER_X),
        .PLAYER_Y (PLAYER_Y)
      ) u_slot (
        .clk        (clk),
        .rst        (rst),
        .clear_all  (!game_active),
        .spawn      (spawn_vec[gi]),
        .spawn_dir  (look),
        .retire     (hit_clear[gi]),
        .frame_tick (frame_tick),
        .px_x       (px_x),
        .px_y       (px_y),
        .active     (active_vec[gi]),
        .hit        (hit_vec[gi])
      );
    end
  endgenerate

  assign slot_active   = active_vec;
  assign cooldown_busy = (cooldown_reg != '0);

endmodule

// File: tb/tb_projectile_engine.sv
// Scoreboard bench for projectile_engine: stimulus queues expected pulses and
// pixel-hit results; a monitor pops and compares whenever the DUT presents them.
module tb_projectile_engine;

  logic       clk = 1'b0;
  logic       rst;
  logic       frame_tick;
  logic       game_active;
  logic [2:0] look;
  logic       shoot;
  logic [3:0] hit_clear;
  logic [9:0] px_x;
  logic [9:0] px_y;
  logic       px_hit;
  logic [3:0] slot_active;
  logic       cooldown_busy;
  logic       shot_fired;
  logic       shot_dropped;

  int checks = 0;
  int errors = 0;

  typedef enum int {EV_FIRED, EV_DROPPED} ev_t;
  ev_t  ev_q[$];
  bit   px_q[$];
  logic q_valid   = 1'b0;
  logic q_valid_d = 1'b0;
  bit   exp_hit;

  projectile_engine dut (
    .clk           (clk),
    .rst           (rst),
    .frame_tick    (frame_tick),
    .game_active   (game_active),
    .look          (look),
    .shoot         (shoot),
    .hit_clear     (hit_clear),
    .px_x          (px_x),
    .px_y          (px_y),
    .px_hit        (px_hit),
    .slot_active   (slot_active),
    .cooldown_busy (cooldown_busy),
    .shot_fired    (shot_fired),
    .shot_dropped  (shot_dropped)
  );

  always #5 clk = ~clk;

  always @(posedge clk) q_valid_d <= q_valid;

  task automatic pulse_seen(input ev_t kind);
    ev_t want;
    checks++;
    if (ev_q.size() == 0) begin
      errors++;
      $display("FAIL pulse: got %s, required none", kind.name());
    end else begin
      want = ev_q.pop_front();
      if (want != kind) begin
        errors++;
        $display("FAIL pulse: got %s, required %s", kind.name(), want.name());
      end else begin
        $display("pulse %s ok at %0t", kind.name(), $time);
      end
    end
  endtask

  always @(negedge clk) begin
    if (q_valid_d) begin
      checks++;
      if (px_q.size() == 0) begin
        errors++;
        $display("FAIL px_hit: result %0b with no query outstanding", px_hit);
      end else begin
        exp_hit = px_q.pop_front();
        if (px_hit !== exp_hit) begin
          errors++;
          $display("FAIL px_hit: got %0b, required %0b at %0t", px_hit, exp_hit, $time);
        end else begin
          $display("query px_hit=%0b ok at %0t", px_hit, $time);
        end
      end
    end
    if (shot_fired === 1'b1)   pulse_seen(EV_FIRED);
    if (shot_dropped === 1'b1) pulse_seen(EV_DROPPED);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic fire(input logic [2:0] d, input bit want_fire, input bit want_drop);
    if (want_fire) ev_q.push_back(EV_FIRED);
    if (want_drop) ev_q.push_back(EV_DROPPED);
    look  = d;
    shoot = 1'b1;
    step();
    step();
    step();
    shoot = 1'b0;
    step();
  endtask

  task automatic query(input int x, input int y, input bit want);
    px_x    = 10'(x);
    px_y    = 10'(y);
    q_valid = 1'b1;
    px_q.push_back(want);
    step();
    q_valid = 1'b0;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end else begin
      $display("check %s = %0h ok", name, act);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; frame_tick = 1'b0; game_active = 1'b1; look = 3'd0;
    shoot = 1'b0; hit_clear = 4'd0; px_x = 10'd0; px_y = 10'd0;
    step(); step();
    check("reset slot_active", 32'(slot_active), 0);
    check("reset cooldown_busy", 32'(cooldown_busy), 0);
    check("reset px_hit", 32'(px_hit), 0);
    check("reset shot_fired", 32'(shot_fired), 0);
    rst = 1'b0;
    step();

    // first shot east, then one frame of movement
    fire(3'd2, 1'b1, 1'b0);
    check("spawn slot_active", 32'(slot_active), 32'h1);
    check("spawn cooldown_busy", 32'(cooldown_busy), 1);
    query(322, 241, 1'b1);
    query(320, 240, 1'b1);
    query(324, 240, 1'b0);
    query(319, 240, 1'b0);
    query(320, 244, 1'b0);
    tick();
    query(324, 240, 1'b1);
    query(327, 243, 1'b1);
    query(323, 240, 1'b0);
    query(328, 240, 1'b0);

    // game inactive wipes everything
    game_active = 1'b0;
    step();
    check("inactive slot_active", 32'(slot_active), 0);
    check("inactive cooldown_busy", 32'(cooldown_busy), 0);
    game_active = 1'b1;
    query(324, 240, 1'b0);

    // cooldown: edge at frame 3 ignored, edge after 8 frames accepted
    fire(3'd2, 1'b1, 1'b0);
    ticks(3);
    fire(3'd2, 1'b0, 1'b0);
    check("cooldown ignore slot_active", 32'(slot_active), 32'h1);
    check("cooldown mid busy", 32'(cooldown_busy), 1);
    ticks(5);
    check("cooldown expired busy", 32'(cooldown_busy), 0);
    fire(3'd2, 1'b1, 1'b0);
    check("second shot slot_active", 32'(slot_active), 32'h3);
    query(352, 240, 1'b1);
    query(320, 240, 1'b1);

    // hit_clear on slot 0 coincident with frame_tick
    hit_clear  = 4'b0001;
    frame_tick = 1'b1;
    step();
    hit_clear  = 4'b0000;
    frame_tick = 1'b0;
    check("hit_clear slot_active", 32'(slot_active), 32'h2);
    query(324, 240, 1'b1);
    query(320, 240, 1'b0);
    query(356, 240, 1'b0);

    // fill all four slots heading south, fifth shot dropped
    game_active = 1'b0;
    step();
    game_active = 1'b1;
    fire(3'd4, 1'b1, 1'b0); ticks(8);
    fire(3'd4, 1'b1, 1'b0); ticks(8);
    fire(3'd4, 1'b1, 1'b0); ticks(8);
    fire(3'd4, 1'b1, 1'b0);
    check("fill slot_active", 32'(slot_active), 32'hF);
    ticks(8);
    check("fill cooldown idle", 32'(cooldown_busy), 0);
    fire(3'd4, 1'b0, 1'b1);
    check("drop cooldown_busy", 32'(cooldown_busy), 0);
    check("drop slot_active", 32'(slot_active), 32'hF);
    query(320, 368, 1'b1);
    query(323, 371, 1'b1);
    query(320, 372, 1'b0);
    query(321, 275, 1'b1);
    query(321, 276, 1'b0);

    // north-west shot leaves through the top edge on tick 61
    game_active = 1'b0;
    step();
    game_active = 1'b1;
    fire(3'd7, 1'b1, 1'b0);
    ticks(60);
    check("nw tick60 slot_active", 32'(slot_active), 32'h1);
    query(80, 0, 1'b1);
    query(83, 3, 1'b1);
    query(84, 0, 1'b0);
    tick();
    check("nw tick61 slot_active", 32'(slot_active), 32'h0);
    query(80, 0, 1'b0);

    // asynchronous reset between clock edges
    fire(3'd2, 1'b1, 1'b0);
    check("pre-reset slot_active", 32'(slot_active), 32'h1);
    query(320, 240, 1'b1);
    px_x = 10'd320;
    px_y = 10'd240;
    step();
    check("pre-reset px_hit", 32'(px_hit), 1);
    #3 rst = 1'b1;
    #1;
    check("async reset px_hit", 32'(px_hit), 0);
    check("async reset slot_active", 32'(slot_active), 0);
    check("async reset cooldown_busy", 32'(cooldown_busy), 0);
    step();
    rst = 1'b0;
    step(); step(); step();

    checks++;
    if (ev_q.size() != 0 || px_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard drain: %0d pulses and %0d queries outstanding, required 0",
               ev_q.size(), px_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/projectile_engine.md
# projectile_engine

Owns all live player projectiles for the shooter: accepts shoot requests from the player controls, spawns projectiles at the player centre in the current look direction, advances them once per video frame, retires them at the screen edge or on a collision clear, and answers per-pixel "is a projectile here" queries for the colour mux that feeds `vga_driver`. It sits between the top-level game FSM (which gates it with `game_active`) and the pixel renderer.

## Interface
Parameters:
- `NUM_SLOTS`, 4: maximum simultaneous projectiles.
- `SPEED`, 4: pixels moved per axis per frame.
- `SIZE`, 4: projectile square edge, pixels.
- `COOLDOWN_FRAMES`, 8: frames between accepted shots.
- `PLAYER_X`, 320 / `PLAYER_Y`, 240: spawn coordinate (top-left of square).

Ports:
- `clk` in 1: system clock.
- `rst` in 1: asynchronous, active-high reset.
- `frame_tick` in 1: one-cycle pulse per frame (end of active video).
- `game_active` in 1: high while the game FSM is in UPDATE.
- `look` in 3: direction 0=N,1=NE,2=E,3=SE,4=S,5=SW,6=W,7=NW.
- `shoot` in 1: raw level from the player control (already synchronised).
- `hit_clear` in NUM_SLOTS: per-slot retire request from collision logic.
- `px_x`, `px_y` in 10 each: pixel being queried.
- `px_hit` out 1: registered, queried pixel lies inside an active projectile.
- `slot_active` out NUM_SLOTS: live-slot mask.
- `cooldown_busy` out 1: cooldown counter non-zero.
- `shot_fired` out 1: one-cycle pulse on accepted shot.
- `shot_dropped` out 1: one-cycle pulse when a shot is refused because all slots are full.

## Operation
- Per slot state: active, x[9:0], y[9:0], dir[2:0]. Reset: all zero; all outputs zero; cooldown zero; shoot edge register zero.
- Shoot request: rising edge of `shoot` (registered previous value).
- Accept when request && `game_active` && cooldown==0 && a free slot exists: lowest-index free slot gets active=1, x=PLAYER_X, y=PLAYER_Y, dir=`look`; cooldown loads COOLDOWN_FRAMES; `shot_fired` pulses next cycle.
- Request with cooldown≠0: ignored silently. Request with all slots active and cooldown==0: `shot_dropped` pulses, cooldown not loaded.
- On `frame_tick`: each active slot moves x+=dx·SPEED, y+=dy·SPEED (dx,dy ∈ {-1,0,+1} from dir). Arithmetic in 11-bit signed; if the new x<0 or >640−SIZE, or new y<0 or >480−SIZE, the slot goes inactive instead. Cooldown decrements if non-zero.
- `hit_clear[i]` deactivates slot i.
- `game_active` low: all slots cleared and cooldown forced to zero every cycle; no spawns.
- Same-cycle priority: clear (game_active low) > hit_clear > move; a spawn in the same cycle as `frame_tick` places the new slot at the spawn point unmoved. hit_clear on a free slot being spawned is ignored (spawn wins).
- Pixel query: hit = OR over active slots of (x ≤ px_x < x+SIZE and y ≤ px_y < y+SIZE), compared against slot state at the query cycle.

## Timing
- `px_hit`: exactly 1 cycle latency from `px_x`/`px_y`; fully pipelined, new query every cycle.
- Shot acceptance: state and `slot_active` update on the clock edge after the `shoot` rising edge is seen (2 edges from raw rise); `shot_fired`/`shot_dropped` assert in that same cycle.
- Movement visible on `slot_active`/`px_hit` from the cycle after `frame_tick`.
- Reset asserted mid-frame: all state cleared immediately, `px_hit` low.

## Configuration
- `PROJECTILE_AUTOFIRE_EN` defined: a held-high `shoot` is a request on every cycle, so firing repeats each time cooldown reaches zero. Undefined: only rising edges request; holding fires once.

## Structure
- Shared package: direction encoding constants (DIR_N..DIR_NW), screen constants H_ACTIVE=640, V_ACTIVE=480, and the slot record typedef (active, x, y, dir).
- Sub-module `projectile_slot`: one slot's registers, move/bounds logic and pixel-hit compare, instantiated NUM_SLOTS times; allocator, cooldown and OR-reduce stay in the parent.

## Test plan
- Reset, game_active=1, shoot rise with look=2 → slot 0 active at (320,240), shot_fired pulse, cooldown_busy=1; after one frame_tick slot 0 at (324,240).
- look=7, fire, 60 frame_ticks → slot deactivates on the tick where y would go below 0 (tick 61 from y=240: 240−4·60=0, then −4).
- Five shoot edges each spaced 8 frames apart, no clears → slots 0–3 fill, fifth gives shot_dropped, cooldown_busy stays 0.
- Shoot edge at frame 3 of cooldown → ignored, no pulse; edge after 8 ticks → accepted.
- hit_clear=4'b0001 on the same cycle as frame_tick → slot 0 inactive, others moved.
- Query px=(322,241) with slot at (320,240) → px_hit=1 one cycle later; px=(324,240) → 0; game_active dropped → all slots clear, px_hit=0.
